// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

   localparam int MDU_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULTU = 2'b00,
      MDU_MULT  = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_DIV   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shared 32-step shift datapath
// feeding the HI/LO registers, start/busy/done handshake.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = MDU_DATA_WIDTH,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   input  logic                  hi_we,
   input  logic                  lo_we,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo,
   output logic                  busy,
   output logic                  done,
   output logic                  div_zero
);

   localparam int W = DATA_WIDTH;

   mdu_state_e           state_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 is_mul_q, sign_q, sign_r_q;
   logic [W-1:0]         rem_q, quo_q, dvs_q;
   logic [W-1:0]         hi_q, lo_q;
   logic                 busy_q, done_q, div_zero_q;

   // Operand decode at accept time
   logic         signed_op, div_op, dz;
   logic [W-1:0] a_abs, b_abs;

   assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
   assign div_op    = (op == MDU_DIVU) || (op == MDU_DIV);
   assign dz        = div_op && (operand_b == '0);
   assign a_abs     = (signed_op && operand_a[W-1]) ? -operand_a : operand_a;
   assign b_abs     = (signed_op && operand_b[W-1]) ? -operand_b : operand_b;

   // Multiply: rem_q:quo_q is the 64-bit accumulator, multiplier shifts out of quo_q.
   // Divide: rem_q is the partial remainder, quotient bits shift into quo_q.
   logic [W:0]   mul_sum, div_sh;
   logic [W+1:0] div_diff;
   logic         div_unused;
   logic [W-1:0] rem_d, quo_d;

   assign mul_sum    = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
   assign div_sh     = {rem_q, quo_q[W-1]};
   assign div_diff   = {1'b0, div_sh} - {2'b0, dvs_q};
   assign div_unused = div_diff[W];

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      if (is_mul_q) begin
         rem_d = mul_sum[W:1];
         quo_d = {mul_sum[0], quo_q[W-1:1]};
      end else if (!div_diff[W+1]) begin
         rem_d = div_diff[W-1:0];
         quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
         rem_d = div_sh[W-1:0];
         quo_d = {quo_q[W-2:0], 1'b0};
      end
   end

   // Sign correction applied on the way into HI/LO
   logic [2*W-1:0] prod, prod_n;
   logic [W-1:0]   q_fin, r_fin, hi_d, lo_d;

   assign prod   = {rem_q, quo_q};
   assign prod_n = sign_q ? -prod : prod;
   assign q_fin  = sign_q ? -quo_q : quo_q;
   assign r_fin  = sign_r_q ? -rem_q : rem_q;
   assign hi_d   = is_mul_q ? prod_n[2*W-1:W] : r_fin;
   assign lo_d   = is_mul_q ? prod_n[W-1:0]   : q_fin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_mul_q   <= 1'b0;
         sign_q     <= 1'b0;
         sign_r_q   <= 1'b0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q     <= 1'b1;
                  div_zero_q <= dz;
                  is_mul_q   <= !div_op;
                  // Divide-by-zero skips RUN; FINISH then emits hi=a, lo=all-ones unsigned
                  sign_q     <= !dz && signed_op && (operand_a[W-1] ^ operand_b[W-1]);
                  sign_r_q   <= !dz && signed_op && operand_a[W-1];
                  dvs_q      <= div_op ? b_abs : a_abs;
                  if (dz) begin
                     state_q <= FINISH;
                     cnt_q   <= '0;
                     rem_q   <= operand_a;
                     quo_q   <= '1;
                  end else begin
                     state_q <= RUN;
                     cnt_q   <= CNT_WIDTH'(W - 1);
                     rem_q   <= '0;
                     quo_q   <= div_op ? a_abs : b_abs;
                  end
               end else begin
                  if (hi_we) hi_q <= operand_a;
                  if (lo_we) lo_q <= operand_a;
               end
            end
            RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               if (cnt_q == '0) state_q <= FINISH;
               else             cnt_q   <= cnt_q - 1'b1;
            end
            FINISH: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, random ops against
// an arithmetic reference, and handshake/reset corner sequences.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] operand_a = '0, operand_b = '0;
   logic        hi_we = 1'b0, lo_we = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int vecs = 0;
   int errs = 0;

   mult_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_we(hi_we), .lo_we(lo_we),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic, returns {div_zero, hi, lo}
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint      sa, sb, q, r;
      case (o)
         2'b00: begin p = 64'(a) * 64'(b); return {1'b0, p}; end
         2'b01: begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa * sb; return {1'b0, q[63:0]};
         end
         2'b10: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            return {1'b0, a % b, a / b};
         end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Start one op, scramble inputs after the accepting edge, wait for done.
   // lat counts cycles after the start edge; the done cycle is lat.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin lat = k; break; end
      end
      rh = hi; rl = lo; rdz = div_zero;
      if (lat == 0) begin
         vecs++; errs++;
         $display("FAIL timeout: no done within 100 cycles, op %0d", o);
      end else begin
         chk("busy_at_done", {31'b0, busy}, 32'd0);
      end
   endtask

   vec_t        tbl[12];
   int          lat, pulses, first_k;
   logic [31:0] rh, rl;
   logic        rdz, drop;
   logic [64:0] m;
   logic [1:0]  ro;
   logic [31:0] ra, rb;

   initial begin
      tbl[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
      tbl[1]  = '{2'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
      tbl[2]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
      tbl[3]  = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 2};
      tbl[4]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34};
      tbl[5]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34};
      tbl[6]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 34};
      tbl[7]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34};
      tbl[8]  = '{2'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2};
      tbl[9]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 34};
      tbl[10] = '{2'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 34};
      tbl[11] = '{2'd2, 32'd5,         32'd10,        32'd5,         32'd0,         1'b0, 34};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_dz", {31'b0, div_zero}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, rh, rl, rdz);
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("tbl%0d_hi", i), rh, tbl[i].hi);
         chk($sformatf("tbl%0d_lo", i), rl, tbl[i].lo);
         chk($sformatf("tbl%0d_dz", i), {31'b0, rdz}, {31'b0, tbl[i].dz});
      end

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         if ($urandom_range(0, 9) == 0) rb = $urandom_range(1, 3);
         m = model(ro, ra, rb);
         run_op(ro, ra, rb, lat, rh, rl, rdz);
         chk($sformatf("rnd%0d_lat", i), 32'(lat), m[64] ? 32'd2 : 32'd34);
         chk($sformatf("rnd%0d_hi op%0d %h %h", i, ro, ra, rb), rh, m[63:32]);
         chk($sformatf("rnd%0d_lo op%0d %h %h", i, ro, ra, rb), rl, m[31:0]);
         chk($sformatf("rnd%0d_dz", i), {31'b0, rdz}, {31'b0, m[64]});
      end

      // mthi + mtlo together in idle
      @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; operand_a = 32'h5555_AAAA;
      @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
      chk("mt_both_hi", hi, 32'h5555_AAAA);
      chk("mt_both_lo", lo, 32'h5555_AAAA);

      // start and mthi during RUN are ignored
      @(negedge clk); start = 1'b1; op = 2'd2; operand_a = 32'd100; operand_b = 32'd7;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1; op = 2'd0; operand_a = 32'h1234; operand_b = 32'd3; hi_we = 1'b1;
      @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin lat = k; break; end
      end
      chk("busy_ign_lat", 32'(lat), 32'd24);
      chk("busy_ign_hi", hi, 32'd2);
      chk("busy_ign_lo", lo, 32'd14);
      @(negedge clk);
      chk("busy_ign_idle", {31'b0, busy}, 32'd0);

      // start held through the done cycle: back-to-back accept
      @(negedge clk); start = 1'b1; op = 2'd0; operand_a = 32'd6; operand_b = 32'd7;
      pulses = 0; drop = 1'b0; first_k = 0;
      for (int k = 1; k <= 90; k++) begin
         @(negedge clk);
         if (drop) begin
            chk("b2b_busy", {31'b0, busy}, 32'd1);
            start = 1'b0; drop = 1'b0;
         end
         if (done) begin
            pulses++;
            chk($sformatf("b2b_hi%0d", pulses), hi, 32'd0);
            chk($sformatf("b2b_lo%0d", pulses), lo, 32'd42);
            if (pulses == 1) begin drop = 1'b1; first_k = k; end
            else chk("b2b_gap", 32'(k - first_k), 32'd34);
         end
      end
      start = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd2);

      // async reset mid-RUN aborts with no writeback
      @(negedge clk); start = 1'b1; op = 2'd1; operand_a = 32'hFFFF_FFFD; operand_b = 32'd5;
      @(posedge clk); #1; start = 1'b0;
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      lo_we = 1'b1; operand_a = 32'h0000_ABCD;
      @(posedge clk); #1; lo_we = 1'b0;
      chk("abort_mtlo", lo, 32'h0000_ABCD);
      chk("abort_mtlo_hi", hi, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
